mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 56 +++++
 rtl/mdu_divstep.sv | 29 ++
 rtl/mdu_seq.sv | 179 +++++++++++++++++
 tb/tb_mdu_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states,
// the op-code decoder and a word sign-extension helper.
package mdu_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned SEL_W = 5;

    localparam logic [SEL_W-1:0] OP_MUL   = 5'd2;
    localparam logic [SEL_W-1:0] OP_DIV   = 5'd3;
    localparam logic [SEL_W-1:0] OP_DIVU  = 5'd4;
    localparam logic [SEL_W-1:0] OP_REM   = 5'd5;
    localparam logic [SEL_W-1:0] OP_REMU  = 5'd6;
    localparam logic [SEL_W-1:0] OP_MULW  = 5'd24;
    localparam logic [SEL_W-1:0] OP_DIVW  = 5'd25;
    localparam logic [SEL_W-1:0] OP_DIVUW = 5'd26;
    localparam logic [SEL_W-1:0] OP_REMW  = 5'd27;
    localparam logic [SEL_W-1:0] OP_REMUW = 5'd28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic mul;
        logic rem;
        logic sgn;
        logic word;
    } op_t;

    function automatic op_t decode_op(input logic [SEL_W-1:0] sel);
        op_t op;
        op = '0;
        case (sel)
            OP_MUL:   begin op.valid = 1'b1; op.mul = 1'b1; end
            OP_DIV:   begin op.valid = 1'b1; op.sgn = 1'b1; end
            OP_DIVU:  begin op.valid = 1'b1; end
            OP_REM:   begin op.valid = 1'b1; op.rem = 1'b1; op.sgn = 1'b1; end
            OP_REMU:  begin op.valid = 1'b1; op.rem = 1'b1; end
            OP_MULW:  begin op.valid = 1'b1; op.mul = 1'b1; op.word = 1'b1; end
            OP_DIVW:  begin op.valid = 1'b1; op.sgn = 1'b1; op.word = 1'b1; end
            OP_DIVUW: begin op.valid = 1'b1; op.word = 1'b1; end
            OP_REMW:  begin op.valid = 1'b1; op.rem = 1'b1; op.sgn = 1'b1; op.word = 1'b1; end
            OP_REMUW: begin op.valid = 1'b1; op.rem = 1'b1; op.word = 1'b1; end
            default:  op = '0;
        endcase
        return op;
    endfunction

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor, and keep the difference if it did not borrow.
module mdu_divstep #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] dsr,
    output logic [N-1:0] rem_nxt,
    output logic [N-1:0] quo_nxt
);

    logic [N:0] trial;
    logic [N:0] diff;

    // rem < dsr always holds, so trial < 2*dsr and diff[N] is a clean borrow flag
    assign trial = {rem, quo[N-1]};
    assign diff  = trial - {1'b0, dsr};

    always_comb begin
        rem_nxt = trial[N-1:0];
        quo_nxt = {quo[N-2:0], 1'b0};
        if (!diff[N]) begin
            rem_nxt = diff[N-1:0];
            quo_nxt = {quo[N-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential radix-2 multiply/divide unit with valid/ready handshakes on both sides.
// One shift-add or restoring step per CALC cycle; trivial cases complete in one cycle.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [4:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res
);

    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          last;

    logic [CW-1:0] cnt;
    logic          mul_q;
    logic          rem_q;
    logic          word_q;
    logic          negq_q;
    logic          negr_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  dsr_q;

    op_t           op_in;
    logic [N-1:0]  a_ext;
    logic [N-1:0]  b_ext;
    logic          a_neg;
    logic          b_neg;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic          direct;
    logic [N-1:0]  direct_res;

    logic [N-1:0]  mul_acc_nxt;
    logic [N-1:0]  div_rem_nxt;
    logic [N-1:0]  div_quo_nxt;
    logic [N-1:0]  raw;
    logic [N-1:0]  fin;

    // Operand decode and precompute at acceptance
    always_comb begin
        op_in = decode_op(sel);
        a_ext = A;
        b_ext = B;
        if (op_in.word) begin
            a_ext = op_in.sgn ? sext_w(A[31:0]) : {{(N-32){1'b0}}, A[31:0]};
            b_ext = op_in.sgn ? sext_w(B[31:0]) : {{(N-32){1'b0}}, B[31:0]};
        end
        a_neg  = op_in.sgn & a_ext[N-1];
        b_neg  = op_in.sgn & b_ext[N-1];
        a_mag  = a_neg ? (~a_ext + N'(1)) : a_ext;
        b_mag  = b_neg ? (~b_ext + N'(1)) : b_ext;
        direct = !op_in.valid || (!op_in.mul && (b_ext == '0));
        if (!op_in.valid) begin
            direct_res = '0;
        end else if (op_in.rem) begin
            direct_res = op_in.word ? sext_w(A[31:0]) : A;
        end else begin
            direct_res = '1;
        end
    end

    mdu_divstep #(.N(N)) u_divstep (
        .rem     (acc_q),
        .quo     (quo_q),
        .dsr     (dsr_q),
        .rem_nxt (div_rem_nxt),
        .quo_nxt (div_quo_nxt)
    );

    // Result formatting applied on the final step's outputs
    always_comb begin
        mul_acc_nxt = acc_q + (quo_q[0] ? dsr_q : '0);
        if (mul_q) begin
            raw = mul_acc_nxt;
        end else if (rem_q) begin
            raw = negr_q ? (~div_rem_nxt + N'(1)) : div_rem_nxt;
        end else begin
            raw = negq_q ? (~div_quo_nxt + N'(1)) : div_quo_nxt;
        end
        fin = word_q ? sext_w(raw[31:0]) : raw;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = direct ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
            last      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
        end
    end

    // Working registers are shared: mul uses acc/multiplier/multiplicand,
    // div uses partial remainder/dividend-quotient/divisor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            mul_q  <= 1'b0;
            rem_q  <= 1'b0;
            word_q <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            acc_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            res    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            mul_q  <= op_in.mul;
            rem_q  <= op_in.rem;
            word_q <= op_in.word;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            acc_q  <= '0;
            quo_q  <= op_in.mul ? b_ext : a_mag;
            dsr_q  <= op_in.mul ? a_ext : b_mag;
            if (direct) res <= direct_res;
        end else if (state == S_CALC && !flush) begin
            cnt <= cnt + CW'(1);
            if (mul_q) begin
                acc_q <= mul_acc_nxt;
                quo_q <= quo_q >> 1;
                dsr_q <= dsr_q << 1;
            end else begin
                acc_q <= div_rem_nxt;
                quo_q <= div_quo_nxt;
            end
            if (last) res <= fin;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases, stall, flush, reset,
// back-to-back and randomized ops against a plain-arithmetic reference model.
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    mdu_seq #(.N(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0] ua, ub, w;
        logic [63:0] r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        r = 64'd0;
        w = 32'd0;
        case (s)
            5'd2:  r = a * b;
            5'd3:  r = (b == 0) ? '1 : (a == MIN64 && sb == -1) ? MIN64 : 64'(sa / sb);
            5'd4:  r = (b == 0) ? '1 : a / b;
            5'd5:  r = (b == 0) ? a : (a == MIN64 && sb == -1) ? 64'd0 : 64'(sa % sb);
            5'd6:  r = (b == 0) ? a : a % b;
            5'd24: w = ua * ub;
            5'd25: w = (ub == 0) ? '1 : (ua == 32'h8000_0000 && wb == -1) ? 32'h8000_0000 : 32'(wa / wb);
            5'd26: w = (ub == 0) ? '1 : ua / ub;
            5'd27: w = (ub == 0) ? ua : (ua == 32'h8000_0000 && wb == -1) ? 32'd0 : 32'(wa % wb);
            5'd28: w = (ub == 0) ? ua : ua % ub;
            default: r = 64'd0;
        endcase
        if (s >= 5'd24 && s <= 5'd28) r = {{32{w[31]}}, w};
        return r;
    endfunction

    function automatic int model_lat(input logic [4:0] s, input logic [63:0] b);
        logic known, is_mul, dz;
        known  = (s >= 5'd2 && s <= 5'd6) || (s >= 5'd24 && s <= 5'd28);
        is_mul = (s == 5'd2) || (s == 5'd24);
        dz     = (s >= 5'd24) ? (b[31:0] == 32'd0) : (b == 64'd0);
        return (known && (is_mul || !dz)) ? 65 : 1;
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; lat counts from acceptance
    task automatic do_op(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output int lat);
        @(negedge clk);
        sel = s; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] r;
        int lat;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 5'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h, want 1 0 0", in_ready, out_valid, res);
        end
        rst_n = 1'b1;
        // leave a nonzero result, then reset in the middle of a new CALC
        do_op(5'd2, 64'd5, 64'd7, r, lat);
        finish_op();
        @(negedge clk);
        sel = 5'd3; A = 64'd1000; B = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b res=%h, want 1 0 0", in_ready, out_valid, res);
        end
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [4:0]  s_t [8] = '{5'd2, 5'd3, 5'd5, 5'd4, 5'd3, 5'd25, 5'd28, 5'd17};
        logic [63:0] a_t [8] = '{64'hFFFF_FFFF_FFFF_FFFF, -64'sd7, -64'sd7, 64'd7, MIN64,
                                 64'h8000_0000, 64'h1_0000_0007, 64'd12345};
        logic [63:0] b_t [8] = '{64'd3, 64'd2, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF, 64'h1_0000_0000, 64'd3};
        logic [63:0] e_t [8] = '{64'hFFFF_FFFF_FFFF_FFFD, -64'sd3, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF,
                                 MIN64, 64'hFFFF_FFFF_8000_0000, 64'd7, 64'd0};
        int          l_t [8] = '{65, 65, 65, 1, 65, 65, 1, 1};
        logic [63:0] r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(s_t[i], a_t[i], b_t[i], r, lat);
            checks++;
            if (r !== e_t[i]) begin
                errors++;
                $display("FAIL directed_res[%0d] sel=%0d: got %h want %h", i, s_t[i], r, e_t[i]);
            end
            checks++;
            if (lat != l_t[i]) begin
                errors++;
                $display("FAIL directed_lat[%0d] sel=%0d: got %0d want %0d", i, s_t[i], lat, l_t[i]);
            end
            finish_op();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_handshake[%0d]: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] r, a, b, exp;
        int lat;
        a = {$urandom, $urandom}; b = {32'd0, $urandom} | 64'd1;
        exp = model(5'd5, a, b);
        do_op(5'd5, a, b, r, lat);
        checks++;
        if (r !== exp) begin
            errors++;
            $display("FAIL stall_res: got %h want %h", r, exp);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== exp) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b res=%h want 1 0 %h", c, out_valid, in_ready, res, exp);
            end
        end
        in_valid = 1'b0;
        finish_op();
    endtask

    task automatic test_flush();
        logic [63:0] r, exp;
        int lat;
        int seen;
        @(negedge clk);
        sel = 5'd4; A = 64'd999_999; B = 64'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles want 0", seen);
        end
        // request in a flush cycle is dropped
        in_valid = 1'b1; flush = 1'b1; sel = 5'd2; A = 64'd3; B = 64'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ignore_valid: in_ready=%b want 1", in_ready);
        end
        exp = model(5'd27, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        do_op(5'd27, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
        checks++;
        if (r !== exp || lat != 65) begin
            errors++;
            $display("FAIL flush_next_op: got %h lat %0d want %h lat 65", r, lat, exp);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [63:0] r, exp;
        int lat;
        do_op(5'd26, 64'hDEAD_0000_0064, 64'd9, r, lat);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; sel = 5'd24; A = 64'h1234_5678_9ABC_DEF0; B = 64'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_same_cycle_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b want 0", in_ready);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = model(5'd24, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF);
        checks++;
        if (res !== exp || lat != 65) begin
            errors++;
            $display("FAIL b2b_second_op: got %h lat %0d want %h lat 65", res, lat, exp);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [4:0]  ops [12] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd0, 5'd31};
        logic [63:0] a, b, r, exp;
        logic [4:0]  s;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            s = ops[$urandom_range(0, 11)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: b = {b[63:32], 32'd0};
                2: b = '1;
                3: a = MIN64;
                4: begin a = {32'd0, 32'h8000_0000}; b = 64'hFFFF_FFFF; end
                5: b = 64'($urandom_range(1, 100));
                default: ;
            endcase
            exp  = model(s, a, b);
            elat = model_lat(s, b);
            do_op(s, a, b, r, lat);
            checks++;
            if (r !== exp) begin
                errors++;
                $display("FAIL random_res[%0d] sel=%0d a=%h b=%h: got %h want %h", i, s, a, b, r, exp);
            end
            checks++;
            if (lat != elat) begin
                errors++;
                $display("FAIL random_lat[%0d] sel=%0d: got %0d want %0d", i, s, lat, elat);
            end
            finish_op();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
